// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the AXI-Lite core controller: register map, bit positions,
// response codes and FSM state types.
package core_ctrl_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ARG    = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_OVR_BIT  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

endpackage

// File: rtl/axi_lite_core_ctrl_if.sv
// AXI4-Lite slave bus bundle for the core controller.
interface axi_lite_core_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/core_ctrl_slot.sv
// Per-core register slot: CTRL/STATUS/ARG/RESULT plus start-pulse generation.
// With CORE_IRQ_EN defined, CTRL bit1 is an interrupt enable and irq_req is exported.
module core_ctrl_slot
  import core_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_reg,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [1:0]          rd_reg,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                busy,
  input  logic                done,
  input  logic [DATA_W-1:0]   result,
  output logic                start,
  output logic [DATA_W-1:0]   arg
`ifdef CORE_IRQ_EN
  ,
  output logic                irq_req
`endif
);

  logic              ctrl_wr_s;
  logic              status_wr_s;
  logic              arg_wr_s;
  logic              start_req_s;
  logic              start_r;
  logic              done_r;
  logic              ovr_r;
  logic [DATA_W-1:0] arg_r;
  logic [DATA_W-1:0] result_r;

  assign ctrl_wr_s   = wr_en && (wr_reg == REG_CTRL) && wr_strb[0];
  assign status_wr_s = wr_en && (wr_reg == REG_STATUS) && wr_strb[0];
  assign arg_wr_s    = wr_en && (wr_reg == REG_ARG);
  assign start_req_s = ctrl_wr_s && wr_data[CTRL_START_BIT];

  // Hardware set of done/ovr takes priority over a W1C in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r  <= 1'b0;
      done_r   <= 1'b0;
      ovr_r    <= 1'b0;
      arg_r    <= '0;
      result_r <= '0;
    end else begin
      start_r <= start_req_s && !busy;
      if (start_req_s && busy) begin
        ovr_r <= 1'b1;
      end else if (status_wr_s && wr_data[STATUS_OVR_BIT]) begin
        ovr_r <= 1'b0;
      end
      if (done) begin
        done_r   <= 1'b1;
        result_r <= result;
      end else if (status_wr_s && wr_data[STATUS_DONE_BIT]) begin
        done_r <= 1'b0;
      end
      for (int b = 0; b < DATA_W/8; b++) begin
        if (arg_wr_s && wr_strb[b]) begin
          arg_r[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

`ifdef CORE_IRQ_EN
  logic irq_en_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      irq_en_r <= wr_data[CTRL_IRQ_EN_BIT];
    end
  end

  assign irq_req = done_r & irq_en_r;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_reg)
      REG_CTRL: begin
`ifdef CORE_IRQ_EN
        rd_data[CTRL_IRQ_EN_BIT] = irq_en_r;
`else
        rd_data = '0;
`endif
      end
      REG_STATUS: begin
        rd_data[STATUS_BUSY_BIT] = busy;
        rd_data[STATUS_DONE_BIT] = done_r;
        rd_data[STATUS_OVR_BIT]  = ovr_r;
      end
      REG_ARG:    rd_data = arg_r;
      REG_RESULT: rd_data = result_r;
      default:    rd_data = '0;
    endcase
  end

  assign start = start_r;
  assign arg   = arg_r;

endmodule

// File: rtl/axi_lite_core_ctrl.sv
// AXI4-Lite register front end controlling N_CORES cores (one core_ctrl_slot each).
// Optional feature macro: CORE_IRQ_EN adds a registered irq output.
module axi_lite_core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int N_CORES = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi_lite_core_ctrl_if.slave       s_axi,
  output logic [N_CORES-1:0]        core_start,
  output logic [N_CORES*DATA_W-1:0] core_arg,
  input  logic [N_CORES-1:0]        core_busy,
  input  logic [N_CORES-1:0]        core_done,
  input  logic [N_CORES*DATA_W-1:0] core_result
`ifdef CORE_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int BSH    = $clog2(DATA_W/8);
  localparam int IW     = $clog2(N_CORES*4);
  localparam int ADDR_W = IW + BSH;

  wr_state_t           wr_state_r;
  logic                awready_r, wready_r, aw_have_r, w_have_r, bvalid_r;
  logic [1:0]          bresp_r;
  logic [ADDR_W-1:0]   awaddr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;

  logic                aw_hs_s, w_hs_s, commit_s, wr_err_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [DATA_W/8-1:0] wr_strb_s;
  logic [IW-1:0]       wr_idx_s, wr_core_s;
  logic [1:0]          wr_reg_s;

  rd_state_t           rd_state_r;
  logic                arready_r, rvalid_r;
  logic [1:0]          rresp_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [IW-1:0]       rd_idx_s, rd_core_s;
  logic [1:0]          rd_reg_s;
  logic                rd_ok_s;
  logic [DATA_W-1:0]   rd_mux_s;

  logic [N_CORES-1:0]  slot_we_s;
  logic [DATA_W-1:0]   slot_rd_s [N_CORES];
  logic                unused_s;

  assign aw_hs_s   = s_axi.S_AXI_AWVALID && awready_r;
  assign w_hs_s    = s_axi.S_AXI_WVALID && wready_r;
  assign wr_addr_s = aw_have_r ? awaddr_r : s_axi.S_AXI_AWADDR;
  assign wr_data_s = w_have_r ? wdata_r : s_axi.S_AXI_WDATA;
  assign wr_strb_s = w_have_r ? wstrb_r : s_axi.S_AXI_WSTRB;
  // A beat completes the pair either from its latch or straight off the bus
  assign commit_s  = (wr_state_r == W_IDLE) && (aw_have_r || aw_hs_s) && (w_have_r || w_hs_s);
  assign wr_idx_s  = wr_addr_s[ADDR_W-1:BSH];
  assign wr_core_s = wr_idx_s >> 2;
  assign wr_reg_s  = wr_idx_s[1:0];
  assign wr_err_s  = (wr_core_s >= IW'(N_CORES)) || (wr_reg_s == REG_RESULT);

  assign rd_idx_s  = s_axi.S_AXI_ARADDR[ADDR_W-1:BSH];
  assign rd_core_s = rd_idx_s >> 2;
  assign rd_reg_s  = rd_idx_s[1:0];
  assign rd_ok_s   = rd_core_s < IW'(N_CORES);
  assign unused_s  = ^{wr_addr_s[BSH-1:0], s_axi.S_AXI_ARADDR[BSH-1:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      aw_have_r  <= 1'b0;
      w_have_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      awaddr_r   <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (commit_s) begin
            wr_state_r <= W_RESP;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            aw_have_r  <= 1'b0;
            w_have_r   <= 1'b0;
            bvalid_r   <= 1'b1;
            bresp_r    <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
          end else begin
            if (aw_hs_s) begin
              aw_have_r <= 1'b1;
              awready_r <= 1'b0;
              awaddr_r  <= s_axi.S_AXI_AWADDR;
            end
            if (w_hs_s) begin
              w_have_r <= 1'b1;
              wready_r <= 1'b0;
              wdata_r  <= s_axi.S_AXI_WDATA;
              wstrb_r  <= s_axi.S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            wr_state_r <= W_IDLE;
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= W_IDLE;
          bvalid_r   <= 1'b0;
          awready_r  <= 1'b1;
          wready_r   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (rd_core_s == IW'(i)) begin
        rd_mux_s = slot_rd_s[i];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // Register values are sampled on the accept edge, so a same-cycle write is not yet visible
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= '0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (s_axi.S_AXI_ARVALID) begin
            rd_state_r <= R_DATA;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rdata_r    <= rd_ok_s ? rd_mux_s : '0;
            rresp_r    <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
          end
        end
        default: begin
          rd_state_r <= R_IDLE;
          arready_r  <= 1'b1;
          rvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_r;
  assign s_axi.S_AXI_WREADY  = wready_r;
  assign s_axi.S_AXI_BVALID  = bvalid_r;
  assign s_axi.S_AXI_BRESP   = bresp_r;
  assign s_axi.S_AXI_ARREADY = arready_r;
  assign s_axi.S_AXI_RVALID  = rvalid_r;
  assign s_axi.S_AXI_RRESP   = rresp_r;
  assign s_axi.S_AXI_RDATA   = rdata_r;

`ifdef CORE_IRQ_EN
  logic [N_CORES-1:0] irq_req_s;
  logic               irq_r;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |irq_req_s;
    end
  end

  assign irq = irq_r;
`endif

  for (genvar i = 0; i < N_CORES; i++) begin : g_slot
    assign slot_we_s[i] = commit_s && !wr_err_s && (wr_core_s == IW'(i));

    core_ctrl_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_en   (slot_we_s[i]),
      .wr_reg  (wr_reg_s),
      .wr_data (wr_data_s),
      .wr_strb (wr_strb_s),
      .rd_reg  (rd_reg_s),
      .rd_data (slot_rd_s[i]),
      .busy    (core_busy[i]),
      .done    (core_done[i]),
      .result  (core_result[i*DATA_W +: DATA_W]),
      .start   (core_start[i]),
      .arg     (core_arg[i*DATA_W +: DATA_W])
`ifdef CORE_IRQ_EN
      ,
      .irq_req (irq_req_s[i])
`endif
    );
  end

endmodule
